// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes, RV32 opcode/funct constants and funct3 decode helper
package alu_pkg;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b0011;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;
  localparam logic [6:0] OPC_OP = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_OR = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;
  function automatic logic [3:0] f3_ctrl(input logic [2:0] f3);
    return f3 == F3_ADD ? ALU_ADD :
           f3 == F3_AND ? ALU_AND :
           f3 == F3_OR  ? ALU_OR  :
           f3 == F3_SLL ? ALU_SLL :
           f3 == F3_SRL ? ALU_SRL : ALU_ILLEGAL;
  endfunction
endpackage

// File: rtl/alu_skid_buf.sv
// alu_skid_buf: 2-entry valid/ready register slice with registered in_ready
module alu_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         rdy_q;
  logic         acc;
  logic         free;
  assign acc = in_valid && in_ready;
  assign free = !out_valid || out_ready;
  assign in_ready = rdy_q && !rst;
  // Output slot refills from skid first, then from input; skid only fills while output is held
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      skid_valid <= 1'b0;
      skid_data <= '0;
      rdy_q <= 1'b1;
    end else begin
      if (free) begin
        out_valid <= skid_valid || acc;
        out_data <= skid_valid ? skid_data : acc ? in_data : out_data;
      end
      if (!free && acc) skid_data <= in_data;
      skid_valid <= !free && (skid_valid || acc);
      rdy_q <= free || !(skid_valid || acc);
    end
  end
endmodule

// File: rtl/alu_op_decoder.sv
// alu_op_decoder: decodes RV32 OP/OP-IMM into ALU control and operands behind a skid buffer
module alu_op_decoder
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_rs1,
  input  logic [DATA_W-1:0] in_rs2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              out_illegal
);
  localparam int PW = 1 + CTRL_W + 2 * DATA_W;
  logic [6:0]        opcode;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic              r_op;
  logic              i_op;
  logic              shift;
  logic              legal;
  logic [3:0]        base;
  logic [3:0]        ctrl;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] b;
  logic [PW-1:0]     pay;
  logic [PW-1:0]     out_data;
  logic              unused_fields;
  assign unused_fields = ^{in_instr[19:15], in_instr[11:7]};
  assign opcode = in_instr[6:0];
  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];
  // Combinational decode; illegal ops keep R-style operands so the token still flows
  always_comb begin
    r_op = opcode == OPC_OP;
    i_op = opcode == OPC_OP_IMM;
    shift = f3 == F3_SLL || f3 == F3_SRL;
    base = f3_ctrl(f3);
    legal = base != ALU_ILLEGAL &&
            ((r_op && (f7 == F7_BASE || (f7 == F7_SUB && f3 == F3_ADD))) ||
             (i_op && (!shift || f7 == F7_BASE)));
    ctrl = !legal ? ALU_ILLEGAL : (r_op && f7 == F7_SUB) ? ALU_SUB : base;
    imm = {{(DATA_W-12){in_instr[31]}}, in_instr[31:20]};
    b = !legal ? in_rs2 :
        shift ? {{(DATA_W-5){1'b0}}, i_op ? in_instr[24:20] : in_rs2[4:0]} :
        i_op ? imm : in_rs2;
    pay = {!legal, CTRL_W'(ctrl), in_rs1, b};
  end
  alu_skid_buf #(.W(PW)) u_skid (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(pay),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
  );
  assign {out_illegal, out_ctrl, out_a, out_b} = out_data;
endmodule

// File: tb/tb_alu_op_decoder.sv
// tb_alu_op_decoder: directed checks of decode, handshake, skid and reset behaviour
module tb_alu_op_decoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'h0;
  logic [31:0] in_rs1 = 32'h0;
  logic [31:0] in_rs2 = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  out_ctrl;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic        out_illegal;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_op_decoder dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_instr(in_instr),
    .in_rs1(in_rs1),
    .in_rs2(in_rs2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl(out_ctrl),
    .out_a(out_a),
    .out_b(out_b),
    .out_illegal(out_illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({out_valid, out_illegal, out_ctrl, out_a, out_b} !== 70'h0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b ill=%b ctrl=%h a=%h b=%h want all zero",
               out_valid, out_illegal, out_ctrl, out_a, out_b);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_decode();
    logic [31:0] ins [12] = '{32'h002081B3, 32'h402081B3, 32'hFFF00093, 32'h00309093,
                              32'h0020D1B3, 32'h0020F1B3, 32'h0F00E093, 32'h8000F093,
                              32'h0020C1B3, 32'h4020D1B3, 32'h4030D093, 32'h000010B7};
    logic [31:0] r1 [12] = '{5, 5, 0, 1, 32'h80, 3, 9, 4, 1, 1, 6, 8};
    logic [31:0] r2 [12] = '{7, 7, 7, 7, 32'h25, 6, 9, 4, 2, 32'h25, 32'h33, 32'h44};
    logic [3:0]  ec [12] = '{4'h0, 4'h1, 4'h0, 4'h8, 4'h3, 4'h2, 4'h4, 4'h2,
                             4'hF, 4'hF, 4'hF, 4'hF};
    logic [31:0] eb [12] = '{7, 7, 32'hFFFFFFFF, 3, 5, 6, 32'hF0, 32'hFFFFF800,
                             2, 32'h25, 32'h33, 32'h44};
    logic        ei [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      in_instr = ins[i];
      in_rs1 = r1[i];
      in_rs2 = r2[i];
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if ({out_valid, out_illegal, out_ctrl, out_a, out_b} !== {1'b1, ei[i], ec[i], r1[i], eb[i]}) begin
        errors++;
        $display("FAIL decode_%0d (instr %h): got v=%b ill=%b ctrl=%h a=%h b=%h want v=1 ill=%b ctrl=%h a=%h b=%h",
                 i, ins[i], out_valid, out_illegal, out_ctrl, out_a, out_b, ei[i], ec[i], r1[i], eb[i]);
      end
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL decode_drain: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_instr = 32'h002081B3;
    in_rs2 = 32'h1;
    in_rs1 = 32'd10;
    in_valid = 1'b1;
    tick();
    checks++;
    if ({out_valid, out_a, in_ready} !== {1'b1, 32'd10, 1'b1}) begin
      errors++;
      $display("FAIL b2b_first: got v=%b a=%0d rdy=%b want v=1 a=10 rdy=1", out_valid, out_a, in_ready);
    end
    in_rs1 = 32'd11;
    tick();
    checks++;
    if ({out_valid, out_a, in_ready} !== {1'b1, 32'd10, 1'b0}) begin
      errors++;
      $display("FAIL b2b_skid_full: got v=%b a=%0d rdy=%b want v=1 a=10 rdy=0", out_valid, out_a, in_ready);
    end
    in_rs1 = 32'd12;
    tick();
    tick();
    checks++;
    if ({out_valid, out_a, in_ready} !== {1'b1, 32'd10, 1'b0}) begin
      errors++;
      $display("FAIL b2b_hold: got v=%b a=%0d rdy=%b want v=1 a=10 rdy=0", out_valid, out_a, in_ready);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid, out_a, in_ready} !== {1'b1, 32'd11, 1'b1}) begin
      errors++;
      $display("FAIL b2b_skid_move: got v=%b a=%0d rdy=%b want v=1 a=11 rdy=1", out_valid, out_a, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_a, in_ready} !== {1'b1, 32'd12, 1'b1}) begin
      errors++;
      $display("FAIL b2b_third: got v=%b a=%0d rdy=%b want v=1 a=12 rdy=1", out_valid, out_a, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_throughput();
    out_ready = 1'b1;
    in_instr = 32'h002081B3;
    in_rs1 = 32'd20;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({out_valid, out_a, in_ready} !== {1'b1, 32'(20 + i), 1'b1}) begin
        errors++;
        $display("FAIL stream_%0d: got v=%b a=%0d rdy=%b want v=1 a=%0d rdy=1",
                 i, out_valid, out_a, in_ready, 20 + i);
      end
      in_rs1 = 32'(21 + i);
      if (i == 3) in_valid = 1'b0;
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_instr = 32'h002081B3;
    in_rs1 = 32'd30;
    in_valid = 1'b1;
    tick();
    in_rs1 = 32'd31;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if ({out_valid, in_ready} !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset: got v=%b rdy=%b want v=0 rdy=0", out_valid, in_ready);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_release: in_ready got %b want 1", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_stale_%0d: out_valid got %b want 0 (a=%0d)", i, out_valid, out_a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_throughput();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
